// File: rtl/mc_control.sv
// mc_control: multi-cycle control sequencer for the 31-instruction MIPS core.
// Defining PERF_CNT_EN adds the cyc_cnt/ret_cnt performance counter outputs.
module mc_control #(
  parameter bit RESET_STATE_TRAP_CLR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        overflow,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_dsel,
  output logic        ir_we,
  output logic [3:0]  aluc,
  output logic        alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam logic [3:0] AluAdd  = 4'h0, AluAddu = 4'h1, AluSub  = 4'h2, AluSubu = 4'h3;
  localparam logic [3:0] AluAnd  = 4'h4, AluOr   = 4'h5, AluXor  = 4'h6, AluNor  = 4'h7;
  localparam logic [3:0] AluSlt  = 4'h8, AluSltu = 4'h9, AluSll  = 4'ha, AluSrl  = 4'hb;
  localparam logic [3:0] AluSra  = 4'hc, AluLui  = 4'hd;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
  typedef enum logic [3:0] {OpAlu, OpImm, OpLw, OpSw, OpBeq, OpBne, OpJ, OpJr, OpJal,
                            OpIll} op_e;

  state_e     state_q;
  logic       trap_q;
  op_e        op;
  logic [3:0] dec_aluc;
  logic       dec_a_sel;
  logic [1:0] dec_b_sel;
  logic       ovf_trap;

  wire [5:0] opcode = instr[31:26];
  wire [5:0] funct  = instr[5:0];

  always_comb begin
    op        = OpIll;
    dec_aluc  = AluAdd;
    dec_a_sel = 1'b0;
    dec_b_sel = 2'd0;
    case (opcode)
      6'h00: begin
        op = OpAlu;
        case (funct)
          6'h20: dec_aluc = AluAdd;
          6'h21: dec_aluc = AluAddu;
          6'h22: dec_aluc = AluSub;
          6'h23: dec_aluc = AluSubu;
          6'h24: dec_aluc = AluAnd;
          6'h25: dec_aluc = AluOr;
          6'h26: dec_aluc = AluXor;
          6'h27: dec_aluc = AluNor;
          6'h2a: dec_aluc = AluSlt;
          6'h2b: dec_aluc = AluSltu;
          6'h00: begin dec_aluc = AluSll; dec_a_sel = 1'b1; end
          6'h02: begin dec_aluc = AluSrl; dec_a_sel = 1'b1; end
          6'h03: begin dec_aluc = AluSra; dec_a_sel = 1'b1; end
          6'h04: dec_aluc = AluSll;
          6'h06: dec_aluc = AluSrl;
          6'h07: dec_aluc = AluSra;
          6'h08: op = OpJr;
          default: op = OpIll;
        endcase
      end
      6'h08: begin op = OpImm; dec_aluc = AluAdd;  dec_b_sel = 2'd1; end
      6'h09: begin op = OpImm; dec_aluc = AluAddu; dec_b_sel = 2'd1; end
      6'h0a: begin op = OpImm; dec_aluc = AluSlt;  dec_b_sel = 2'd1; end
      6'h0b: begin op = OpImm; dec_aluc = AluSltu; dec_b_sel = 2'd1; end
      6'h0c: begin op = OpImm; dec_aluc = AluAnd;  dec_b_sel = 2'd2; end
      6'h0d: begin op = OpImm; dec_aluc = AluOr;   dec_b_sel = 2'd2; end
      6'h0e: begin op = OpImm; dec_aluc = AluXor;  dec_b_sel = 2'd2; end
      6'h0f: begin op = OpImm; dec_aluc = AluLui;  dec_b_sel = 2'd2; end
      6'h23: begin op = OpLw;  dec_aluc = AluAddu; dec_b_sel = 2'd1; end
      6'h2b: begin op = OpSw;  dec_aluc = AluAddu; dec_b_sel = 2'd1; end
      6'h04: begin op = OpBeq; dec_aluc = AluSubu; end
      6'h05: begin op = OpBne; dec_aluc = AluSubu; end
      6'h02: op = OpJ;
      6'h03: op = OpJal;
      default: op = OpIll;
    endcase
  end

  // Only add/addi/sub carry ADD/SUB codes among the ALU-writing classes.
  assign ovf_trap = overflow && (op == OpAlu || op == OpImm) &&
                    (dec_aluc == AluAdd || dec_aluc == AluSub);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      trap_q  <= 1'b0;
    end else begin
      if (RESET_STATE_TRAP_CLR && state_q == StFetch) trap_q <= 1'b0;
      unique case (state_q)
        StFetch:  if (mem_ack) state_q <= StDecode;
        StDecode: begin
          if (op == OpIll) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (ovf_trap) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
          end else begin
            case (op)
              OpAlu, OpImm, OpJal: state_q <= StWb;
              OpLw, OpSw:          state_q <= StMem;
              default:             state_q <= StFetch;
            endcase
          end
        end
        StMem:   if (mem_ack) state_q <= (op == OpLw) ? StWb : StFetch;
        StWb:    state_q <= StFetch;
        StTrap:  state_q <= StTrap;
        default: state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_dsel  = 1'b0;
    ir_we     = 1'b0;
    aluc      = 4'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 2'd0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    reg_we    = 1'b0;
    reg_dst   = 2'd0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    trap      = 1'b0;
    // Async gating: a reset mid-access drops mem_req without waiting for a clock.
    if (!rst) begin
      trap = trap_q;
      if (state_q == StExec || state_q == StMem || state_q == StWb) begin
        aluc      = dec_aluc;
        alu_a_sel = dec_a_sel;
        alu_b_sel = dec_b_sel;
      end
      unique case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
          pc_we   = mem_ack;
        end
        StExec: begin
          case (op)
            OpBeq: begin pc_we = zero;  pc_sel = zero ? 2'd1 : 2'd0;  retire = 1'b1; end
            OpBne: begin pc_we = !zero; pc_sel = !zero ? 2'd1 : 2'd0; retire = 1'b1; end
            OpJ:   begin pc_we = 1'b1;  pc_sel = 2'd2; retire = 1'b1; end
            OpJr:  begin pc_we = 1'b1;  pc_sel = 2'd3; retire = 1'b1; end
            default: ;
          endcase
        end
        StMem: begin
          mem_req  = 1'b1;
          mem_dsel = 1'b1;
          mem_we   = (op == OpSw);
          retire   = mem_ack && (op == OpSw);
        end
        StWb: begin
          reg_we  = 1'b1;
          retire  = 1'b1;
          reg_dst = (op == OpAlu) ? 2'd1 : (op == OpJal) ? 2'd2 : 2'd0;
          wb_sel  = (op == OpLw) ? 2'd1 : (op == OpJal) ? 2'd2 : 2'd0;
          if (op == OpJal) begin
            pc_we  = 1'b1;
            pc_sel = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= 32'd0;
      ret_cnt <= 32'd0;
    end else begin
      if (state_q != StTrap) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle control sequencer for the 31-instruction MIPS core. It is the driving end of the ALU interface: it decodes the instruction register, issues the 4-bit aluc operation code and the operand selects, and consumes the ALU zero/overflow flags. It also sequences fetch, memory access, writeback and PC update through a shared memory port with a req/ack handshake.

Parameters:
RESET_STATE_TRAP_CLR, 1, 1 = leaving reset always clears the trap output; 0 = trap is cleared only by rst (reserved, tie to 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
instr  in  32  instruction register contents (valid from DECODE onward)
zero  in  1  ALU zero flag
overflow  in  1  ALU overflow flag
mem_ack  in  1  memory completes the current request this cycle
mem_req  out  1  memory request (fetch or data)
mem_we  out  1  data write (sw); 0 = read
mem_dsel  out  1  0 = address from PC (fetch), 1 = address from ALU result
ir_we  out  1  load instruction register
aluc  out  4  ALU op: ADD 0000, ADDU 0001, SUB 0010, SUBU 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, SLT 1000, SLTU 1001, SLL 1010, SRL 1011, SRA 1100, LUI 1101
alu_a_sel  out  1  0 = rs, 1 = shamt zero-extended
alu_b_sel  out  2  0 = rt, 1 = sign-ext imm16, 2 = zero-ext imm16
pc_we  out  1  PC write enable
pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs
reg_we  out  1  register file write
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
wb_sel  out  2  0 = ALU result, 1 = memory data, 2 = PC
retire  out  1  one-cycle pulse on the last cycle of each instruction
trap  out  1  sticky: overflow or illegal instruction

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Async rst forces FETCH and trap=0. All outputs are gated to 0 while rst is high.
- FETCH: mem_req=1, mem_dsel=0, mem_we=0. mem_ack is accepted in any cycle mem_req is high, including the first; an ack while mem_req=0 is ignored. On ack: ir_we=1, pc_we=1, pc_sel=0, then DECODE.
- DECODE: one cycle, no outputs. Illegal opcode/funct -> TRAP.
- EXEC: aluc and selects valid for the whole cycle.
  - R-type ALU and shift ops -> WB (reg_dst=1). sll/srl/sra use alu_a_sel=1; *v shifts use alu_a_sel=0.
  - addi/slti use b_sel=1; addiu/sltiu use b_sel=1 with aluc ADDU/SLTU; andi/ori/xori use b_sel=2; lui uses aluc LUI, b_sel=2. All of these -> WB (reg_dst=0).
  - lw/sw: aluc ADDU, b_sel=1 -> MEM.
  - beq/bne: aluc SUBU, b_sel=0. Taken when zero==1 (beq) or zero==0 (bne): pc_we=1, pc_sel=1. Retire, -> FETCH.
  - j: pc_we=1, pc_sel=2, retire -> FETCH. jr: pc_sel=3, retire -> FETCH. jal -> WB.
  - overflow==1 with aluc ADD or SUB (add, addi, sub) -> TRAP, no writeback, no retire.
- MEM: mem_req=1, mem_dsel=1, mem_we=1 for sw; ALU operands held. On ack: lw -> WB; sw retires -> FETCH.
- WB: reg_we=1 for one cycle, retire. wb_sel=1 for lw, otherwise 0. For jal: reg_dst=2, wb_sel=2 (PC already holds PC+4), with pc_we=1 and pc_sel=2 on the same edge. Then -> FETCH.
- TRAP: trap=1, all other outputs 0. The block stays in TRAP until rst.
- Latency with zero-wait ack: beq/bne/j/jr 3 cycles; R-type/imm/sw/jal 4 cycles; lw 5 cycles. Each wait cycle on mem_ack adds 1.
- Reset during MEM or FETCH abandons the access. mem_req drops asynchronously, and the memory must tolerate the dropped request.

Optional Feature:
PERF_CNT_EN: when defined, adds outputs cyc_cnt[31:0] and ret_cnt[31:0]. cyc_cnt increments every cycle outside reset and TRAP. ret_cnt increments on retire. Both reset to 0 and wrap at 2^32. When not defined, these ports and their counters do not exist.

Test Plan:
- Reset, instr=0x00221821 (addu $3,$1,$2), mem_ack tied 1 -> EXEC shows aluc=0001, a_sel=0, b_sel=0; WB on cycle 4 shows reg_we=1, reg_dst=1, wb_sel=0, retire=1.
- beq with zero=1 -> EXEC aluc=0011, pc_we=1, pc_sel=1, retire on cycle 3. Repeat with zero=0 -> pc_we=0 in EXEC. bne is the inverse.
- lw with data ack delayed 3 cycles -> MEM holds mem_req=1, mem_dsel=1, mem_we=0 for 4 cycles; then WB with wb_sel=1, reg_dst=0.
- add with overflow=1 in EXEC -> trap=1 next cycle; reg_we never asserts; trap stays 1 for 20 cycles until rst.
- rst asserted mid-MEM of sw -> mem_req and mem_we go 0 immediately; after release, FETCH with mem_req=1, mem_dsel=0.
- sll $2,$3,4 -> aluc=1010, alu_a_sel=1. jal -> WB shows reg_dst=2, wb_sel=2, reg_we=1, pc_we=1, pc_sel=2 in the same cycle.
